cdc_fifo_wptr_full: RTL and testbench

//  Write-side pointer and full-flag logic for an asynchronous (dual-clock) FIFO.
//  - Keeps a binary write counter and derives the RAM write address from it.
//  - Publishes a Gray-coded write pointer for synchronisation into the read domain.
//  - Compares its next Gray pointer against the read pointer (already 2-FF

---
 rtl/cdc_fifo_wptr_full.sv | 74 +++++++
 tb/tb_cdc_fifo_wptr_full.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_wptr_full.sv
// Write-side pointer and full/almost-full flag logic for a dual-clock FIFO.
// ADDR_SIZE must be at least 2 so the full comparison can invert the top two Gray bits.
module cdc_fifo_wptr_full #(
    parameter int ADDR_SIZE = 4
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_inc,
    input  logic [ADDR_SIZE:0]   w_q2_rptr,
    output logic                 w_almost_full,
    output logic                 w_full,
    output logic [ADDR_SIZE:0]   w_ptr,
    output logic [ADDR_SIZE-1:0] w_addr
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] w_bin_q;
    logic [PW-1:0] w_bin_d;
    logic [PW-1:0] w_gray_q;
    logic [PW-1:0] w_gray_d;
    logic [PW-1:0] bin_nn;
    logic [PW-1:0] gray_nn;
    logic [PW-1:0] full_cmp;
    logic          w_full_q;
    logic          w_full_d;
    logic          w_afull_q;
    logic          w_afull_d;
    logic          w_accept;

    assign w_accept = w_inc & ~w_full_q;
    assign w_bin_d  = w_bin_q + {{(PW-1){1'b0}}, w_accept};
    assign bin_nn   = w_bin_d + {{(PW-1){1'b0}}, 1'b1};

    // Binary-to-Gray for the next pointer and the one after it.
    generate
        for (genvar gi = 0; gi < ADDR_SIZE; gi++) begin : g_gray
            assign w_gray_d[gi] = w_bin_d[gi] ^ w_bin_d[gi+1];
            assign gray_nn[gi]  = bin_nn[gi] ^ bin_nn[gi+1];
        end
    endgenerate
    assign w_gray_d[ADDR_SIZE] = w_bin_d[ADDR_SIZE];
    assign gray_nn[ADDR_SIZE]  = bin_nn[ADDR_SIZE];

    // The write pointer equals this value exactly when it is one lap ahead of the read pointer.
    assign full_cmp = {~w_q2_rptr[ADDR_SIZE:ADDR_SIZE-1], w_q2_rptr[ADDR_SIZE-2:0]};

    always_comb begin
        w_full_d  = 1'b0;
        w_afull_d = 1'b0;
        w_full_d  = (w_gray_d == full_cmp);
        w_afull_d = (gray_nn == full_cmp) & ~w_full_d;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_bin_q   <= '0;
            w_gray_q  <= '0;
            w_full_q  <= 1'b0;
            w_afull_q <= 1'b0;
        end else begin
            w_bin_q   <= w_bin_d;
            w_gray_q  <= w_gray_d;
            w_full_q  <= w_full_d;
            w_afull_q <= w_afull_d;
        end
    end

    assign w_ptr         = w_gray_q;
    assign w_addr        = w_bin_q[ADDR_SIZE-1:0];
    assign w_full        = w_full_q;
    assign w_almost_full = w_afull_q;

endmodule

// File: tb/tb_cdc_fifo_wptr_full.sv
// Randomised scoreboard bench for cdc_fifo_wptr_full: a write/read occupancy model
// predicts every post-edge output, a monitor compares them one cycle later.
module tb_cdc_fifo_wptr_full;

    localparam int AS    = 4;
    localparam int DEPTH = 1 << AS;
    localparam int LAP   = 2 * DEPTH;

    logic          w_clk = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          w_inc = 1'b0;
    logic [AS:0]   w_q2_rptr = '0;
    logic          w_almost_full;
    logic          w_full;
    logic [AS:0]   w_ptr;
    logic [AS-1:0] w_addr;

    cdc_fifo_wptr_full #(.ADDR_SIZE(AS)) dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_inc        (w_inc),
        .w_q2_rptr    (w_q2_rptr),
        .w_almost_full(w_almost_full),
        .w_full       (w_full),
        .w_ptr        (w_ptr),
        .w_addr       (w_addr)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        int ptr;
        int addr;
        int full;
        int afull;
        int inc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model: total writes and reads since reset.
    int   wcnt = 0;
    int   rcnt = 0;
    bit   m_full = 1'b0;

    function automatic int gray(input int n);
        int b;
        b = n % LAP;
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit inc, input bit rd);
        exp_t e;
        int   occ;
        @(negedge w_clk);
        if (rd && rcnt < wcnt) rcnt++;
        w_inc     = inc;
        w_q2_rptr = (AS+1)'(gray(rcnt));
        if (inc && !m_full) wcnt++;
        occ     = wcnt - rcnt;
        m_full  = (occ == DEPTH);
        e.ptr   = gray(wcnt);
        e.addr  = wcnt % DEPTH;
        e.full  = (occ == DEPTH) ? 1 : 0;
        e.afull = (occ == DEPTH - 1) ? 1 : 0;
        e.inc   = int'(inc);
        exp_q.push_back(e);
    endtask

    // Asynchronous assertion away from any edge, release on a falling edge.
    task automatic do_reset();
        @(posedge w_clk);
        #2;
        w_rst_n = 1'b0;
        w_inc   = 1'b0;
        #1;
        check("rst_ptr",   int'(w_ptr), 0);
        check("rst_addr",  int'(w_addr), 0);
        check("rst_full",  int'(w_full), 0);
        check("rst_afull", int'(w_almost_full), 0);
        wcnt = 0;
        rcnt = 0;
        m_full = 1'b0;
        w_q2_rptr = '0;
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
    endtask

    task automatic settle();
        @(posedge w_clk);
        #2;
    endtask

    always @(posedge w_clk) begin
        #1;
        if (w_rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: inc=%0d ptr=%b addr=%0d full=%0b afull=%0b", n_txn, e.inc,
                     w_ptr, w_addr, w_full, w_almost_full);
            check("ptr",   int'(w_ptr), e.ptr);
            check("addr",  int'(w_addr), e.addr);
            check("full",  int'(w_full), e.full);
            check("afull", int'(w_almost_full), e.afull);
            check("flags_exclusive", int'(w_full & w_almost_full), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check("por_ptr",  int'(w_ptr), 0);
        check("por_full", int'(w_full), 0);
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;

        // Four spaced single writes.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        settle();
        check("four_ptr",  int'(w_ptr), 5'b00110);
        check("four_addr", int'(w_addr), 4'b0100);
        check("four_full", int'(w_full), 0);

        // Mid-operation reset, then fill to one free slot.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0);
        settle();
        check("af_afull", int'(w_almost_full), 1);
        check("af_full",  int'(w_full), 0);
        check("af_addr",  int'(w_addr), 4'b1111);

        step(1'b1, 1'b0);
        settle();
        check("full_afull", int'(w_almost_full), 0);
        check("full_full",  int'(w_full), 1);
        check("full_ptr",   int'(w_ptr), 5'b11000);
        check("full_addr",  int'(w_addr), 0);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        settle();
        check("hold_full", int'(w_full), 1);
        check("hold_ptr",  int'(w_ptr), 5'b11000);
        check("hold_addr", int'(w_addr), 0);

        step(1'b0, 1'b1);
        settle();
        check("rd_full",  int'(w_full), 0);
        check("rd_afull", int'(w_almost_full), 1);
        step(1'b1, 1'b0);
        settle();
        check("refull_full", int'(w_full), 1);
        check("refull_ptr",  int'(w_ptr), 5'b11001);

        // Random traffic across many laps, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end
        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
